// File: rtl/mips_multi_pkg.sv
// Shared definitions for the multicycle MIPS main control unit: opcodes,
// state encodings, datapath select codes and the per-state control vector.
package mips_multi_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multi_ctrl_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface mips_multi_ctrl_fsm_if;

  logic [5:0] opcode;
  logic       zero;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, zero,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, state_dbg
  );

endinterface

// File: rtl/mips_multi_ctrl_outdec.sv
// Moore output decode: current state -> datapath control vector.
module mips_multi_ctrl_outdec
  import mips_multi_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: zeroing the whole vector first keeps every field assigned on every
    // path, so no latch is inferred and unlisted outputs default to 0.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;  // HALT and unused encodings drive nothing
    endcase
  end

endmodule

// File: rtl/mips_multi_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic, sticky
// illegal-opcode flag, reset gating of the enables and the Mealy pc_en term.
module mips_multi_ctrl_fsm
  import mips_multi_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multi_ctrl_fsm_if.master bus
);

  state_t state_q;
  state_t state_d;
  logic   illegal_q;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && !is_supported(bus.opcode))
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;  // write-back states, BRANCH, JUMP, 13-15
    endcase
  end

  mips_multi_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Enables are suppressed during reset so no datapath register loads garbage.
  assign bus.mem_write  = ctrl.mem_write & ~reset;
  assign bus.ir_write   = ctrl.ir_write  & ~reset;
  assign bus.reg_write  = ctrl.reg_write & ~reset;
  assign bus.pc_en      = (ctrl.pc_write | (ctrl.branch & bus.zero)) & ~reset;

  assign bus.iord       = ctrl.iord;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.illegal_op = illegal_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mips_multi_ctrl_fsm.sv
// Self-checking bench for mips_multi_ctrl_fsm: table-driven instruction
// sequences plus hand-written reset/halt cases, checked through a scoreboard.
module tb_mips_multi_ctrl_fsm;

  logic clk = 1'b0;
  logic reset0 = 1'b1;
  logic reset1 = 1'b1;

  always #5 clk = ~clk;

  mips_multi_ctrl_fsm_if bus0 ();
  mips_multi_ctrl_fsm_if bus1 ();

  mips_multi_ctrl_fsm #(.ILLEGAL_HALT(1'b0)) dut0 (.clk(clk), .reset(reset0), .bus(bus0));
  mips_multi_ctrl_fsm #(.ILLEGAL_HALT(1'b1)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));

  // {state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
  //  alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op}
  logic [18:0] act0, act1;
  assign act0 = {bus0.state_dbg, bus0.iord, bus0.mem_write, bus0.ir_write, bus0.reg_dst,
                 bus0.mem_to_reg, bus0.reg_write, bus0.alu_src_a, bus0.alu_src_b,
                 bus0.alu_op, bus0.pc_src, bus0.pc_en, bus0.illegal_op};
  assign act1 = {bus1.state_dbg, bus1.iord, bus1.mem_write, bus1.ir_write, bus1.reg_dst,
                 bus1.mem_to_reg, bus1.reg_write, bus1.alu_src_a, bus1.alu_src_b,
                 bus1.alu_op, bus1.pc_src, bus1.pc_en, bus1.illegal_op};

  typedef struct {
    logic [5:0] opcode;
    logic       zero;
    int         len;
    logic [3:0] states [5];
    string      name;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [18:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  logic ill_m [2];
  int   errors = 0;
  int   checks = 0;

  function automatic logic legal_op(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference outputs per state, straight from the state table.
  function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic z,
                                          input logic rst, input logic ill);
    logic iord, mw, irw, rd, mtr, rw, asa, pen;
    logic [1:0] asb, aop, psrc;
    {iord, mw, irw, rd, mtr, rw, asa, pen} = '0;
    {asb, aop, psrc} = '0;
    case (st)
      4'd0:  begin irw = 1'b1; pen = 1'b1; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin mtr = 1'b1; rw = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pen = z; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin psrc = 2'b10; pen = 1'b1; end
      default: ;
    endcase
    if (rst) {mw, irw, rw, pen} = '0;
    return {st, iord, mw, irw, rd, mtr, rw, asa, asb, aop, psrc, pen, ill};
  endfunction

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d vec=%b, expected state=%0d vec=%b",
               nm, act[18:15], act, exp[18:15], exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare at negedge.
  task automatic step(input bit sel, input logic rst, input logic [5:0] op,
                      input logic z, input logic [3:0] st, input string nm);
    sb_t e;
    if (sel) begin
      reset1 = rst; bus1.opcode = op; bus1.zero = z;
    end else begin
      reset0 = rst; bus0.opcode = op; bus0.zero = z;
    end
    e.sel  = sel;
    e.exp  = exp_vec(st, z, rst, ill_m[sel]);
    e.name = $sformatf("%s[st%0d]", nm, st);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check(e.name, e.sel ? act1 : act0, e.exp);
    if (rst) ill_m[sel] = 1'b0;
    else if (st == 4'd1 && !legal_op(op)) ill_m[sel] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [5:0] op, input logic z, input int len,
                         input logic [19:0] seq, input string nm);
    vec_t v;
    v.opcode = op;
    v.zero   = z;
    v.len    = len;
    for (int i = 0; i < 5; i++) v.states[i] = seq[19 - 4*i -: 4];
    v.name   = nm;
    vecs.push_back(v);
  endtask

  initial begin
    ill_m[0] = 1'b0;
    ill_m[1] = 1'b0;
    bus0.opcode = 6'b100011; bus0.zero = 1'b0;
    bus1.opcode = 6'b111111; bus1.zero = 1'b0;

    add_vec(6'b100011, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4},   "lw");
    add_vec(6'b101011, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0},   "sw");
    add_vec(6'b000000, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},   "rtype");
    add_vec(6'b000100, 1'b1, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},   "beq_taken");
    add_vec(6'b000100, 1'b0, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},   "beq_not_taken");
    add_vec(6'b000010, 1'b0, 3, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0},  "jump");
    add_vec(6'b001000, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0},  "addi");
    add_vec(6'b111111, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0},   "illegal");
    add_vec(6'b000000, 1'b1, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},   "rtype_after_illegal");

    // Reset held two cycles on dut0; dut1 stays in reset meanwhile.
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 6'b100011, 1'b0, 4'd0, "reset0_c1");
    step(1'b0, 1'b1, 6'b100011, 1'b0, 4'd0, "reset0_c2");

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].len; i++)
        step(1'b0, 1'b0, vecs[k].opcode, vecs[k].zero, vecs[k].states[i], vecs[k].name);
    end

    // Reset arrives while LW sits in MEMRD: enables forced off, flag cleared.
    step(1'b0, 1'b0, 6'b100011, 1'b0, 4'd0, "lw_midreset");
    step(1'b0, 1'b0, 6'b100011, 1'b0, 4'd1, "lw_midreset");
    step(1'b0, 1'b0, 6'b100011, 1'b0, 4'd2, "lw_midreset");
    step(1'b0, 1'b1, 6'b100011, 1'b0, 4'd3, "lw_midreset_rst");
    step(1'b0, 1'b0, 6'b101011, 1'b0, 4'd0, "after_midreset");
    step(1'b0, 1'b0, 6'b101011, 1'b0, 4'd1, "after_midreset");
    step(1'b0, 1'b0, 6'b101011, 1'b0, 4'd2, "after_midreset");
    step(1'b0, 1'b0, 6'b101011, 1'b0, 4'd5, "after_midreset");

    // Halting variant: park dut0 in reset and exercise dut1.
    reset0 = 1'b1;
    step(1'b1, 1'b1, 6'b111111, 1'b0, 4'd0, "halt_reset");
    step(1'b1, 1'b0, 6'b111111, 1'b0, 4'd0, "halt_seq");
    step(1'b1, 1'b0, 6'b111111, 1'b1, 4'd1, "halt_seq");
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 6'b100011, 1'b1, 4'd12, "halt_hold");
    step(1'b1, 1'b1, 6'b100011, 1'b0, 4'd12, "halt_rst");
    step(1'b1, 1'b0, 6'b100011, 1'b0, 4'd0, "halt_recovered");
    step(1'b1, 1'b0, 6'b100011, 1'b0, 4'd1, "halt_recovered");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multi_ctrl_fsm.md
Name: mips_multi_ctrl_fsm

Overview:
Multicycle MIPS main control unit; Moore FSM that sequences FETCH/DECODE/execute steps for each instruction.
Drives the write enables and mux selects of the datapath state registers (PC, IR, MDR, A/B, ALUOut), memory and register file.
Sits directly upstream of the datapath register stages: its enables (ir_write, pc_en, reg_write, mem_write) are what load those registers each cycle.
Also emits alu_op for the downstream ALU decoder.

Parameters:
ILLEGAL_HALT, 0, 0: unsupported opcode returns to FETCH and sets illegal_op; 1: enter HALT and stay there until reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  instr[31:26] from IR
zero  in  1  ALU zero flag, combinational from the ALU in the BRANCH state
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write enable
ir_write  out  1  IR load enable
reg_dst  out  1  register write address: 0 = rt, 1 = rd
mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A: 0 = PC, 1 = A
alu_src_b  out  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = use funct
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC load: pc_write | (branch & zero)
illegal_op  out  1  sticky flag; set by an unsupported opcode in DECODE
state_dbg  out  4  current state encoding

Behaviour:
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- Reset is synchronous and active-high; clock is clk, reset is reset.
- reset sampled high at posedge: state <= FETCH (0), illegal_op <= 0.
- While reset is high: mem_write, ir_write, reg_write and pc_en are forced to 0. All other outputs follow the decode of the current state.
- All outputs except illegal_op are a pure function of state; no opcode or zero look-ahead except pc_en.
- Each state lasts exactly one cycle. Output values not listed for a state are 0.
- State encodings and transitions:
  - FETCH (0): iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1. Next: DECODE.
  - DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00. Next by opcode:
    - LW or SW -> MEMADR
    - RTYPE -> EXECUTE
    - BEQ -> BRANCH
    - ADDI -> ADDIEX
    - J -> JUMP
    - any other opcode -> illegal handling (below)
  - MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if LW, MEMWR if SW.
  - MEMRD (3): iord=1. Next: MEMWB.
  - MEMWB (4): reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR (5): iord=1, mem_write=1. Next: FETCH.
  - EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB (7): reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Next: FETCH.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB (10): reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
  - JUMP (11): pc_src=10, pc_write=1. Next: FETCH.
  - HALT (12): all enables 0. Self-loop until reset.
- Illegal handling: in DECODE with an unsupported opcode, illegal_op <= 1 (stays set until reset). Next state is FETCH if ILLEGAL_HALT=0, HALT if ILLEGAL_HALT=1.
- Unused encodings 13-15: all enables 0; next state FETCH (recovery).
- Latency in cycles: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
- pc_en is the only Mealy term. In BRANCH, zero=0 gives pc_en=0.
- Reset asserted mid-instruction: the next state is FETCH regardless of the current state; no enable is asserted during the reset cycle.

Decomposition:
- Shared package mips_multi_pkg holds:
  - opcode localparams OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - 4-bit state localparams S_FETCH..S_HALT
  - alu_op codes and alu_src_b / pc_src select codes
- One sub-module: mips_multi_ctrl_outdec, a combinational decode of state -> control vector. The top level holds the state register, the next-state logic, the illegal_op flop, the reset gating and the pc_en term.

Test Plan:
- Reset held for 2 cycles, then released with opcode=100011 -> state_dbg sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. ir_write=1 and pc_en=1 only in state 0.
- opcode=101011 -> states 0,1,2,5,0. mem_write=1 and iord=1 in state 5 only. reg_write stays 0 throughout.
- opcode=000100, zero=1 -> pc_en=1 with pc_src=01 in state 8. Repeat with zero=0 -> pc_en=0 in state 8. Both return to state 0 next cycle.
- opcode=000010 -> states 0,1,11,0, with pc_src=10 and pc_en=1 in state 11. Then opcode=001000 -> states 0,1,9,10,0, with reg_dst=0 in state 10.
- opcode=111111 with ILLEGAL_HALT=0 -> illegal_op=1 from the cycle after DECODE, next state 0, flag stays 1. With ILLEGAL_HALT=1 -> state_dbg=12 held for 10 cycles with all enables 0.
- reset pulsed high in state 3 (LW) -> mem_write, reg_write and pc_en stay 0 during the reset cycle. Next state_dbg=0 and illegal_op=0.
